pipe_control_unit: RTL and testbench

Pipelined control and hazard unit for the MIPS pipeline processor, replacing the purely combinational opcode decoder. It decodes the ID-stage opcode, carries the control word and destination register through the ID/EX, MEM and WB stage registers, and detects load-use hazards. It drives stall, bubble and flush signals to the PC and IF/ID registers, and its MEM stage depth is parametrised for multi-cycle data memory.

---
 rtl/pipe_control_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// -----------------------------------------------------------------------------
// pipe_control_unit
//
// Pipelined control and hazard unit for the MIPS pipeline. It decodes the
// ID-stage opcode and carries the control word and destination register
// through the ID/EX register, MEM_LATENCY MEM stage registers and the WB
// register. It also detects load-use hazards and drives the stall, bubble and
// flush controls for the PC and IF/ID registers.
//
// Parameters:
//   REG_ADDR_W  register-address width
//   MEM_LATENCY number of MEM pipeline stages (1..4)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_valid, id_opcode           ID instruction valid flag and opcode
//   id_rs, id_rt, id_rd           ID register fields
//   ex_flush                      taken branch resolved in EX
//   pc_write_en, ifid_write_en    PC / IF/ID load enables (low on stall)
//   ifid_flush, id_jump           IF/ID bubble request, jump taken in ID
//   ex_*                          EX-stage controls and destination
//   mem_read, mem_write, mem_dest MEM-stage controls and destination
//   wb_reg_write, wb_memto_reg    WB-stage controls
//   wb_dest                       WB-stage destination
//   illegal_op, illegal_opcode    sticky illegal-opcode trap
//
// Build option: define ILLEGAL_OP_TRAP_EN to enable the illegal-opcode trap;
// otherwise illegal_op and illegal_opcode are tied to 0.
// -----------------------------------------------------------------------------
module pipe_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_flush,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  id_jump,
  output logic                  ex_alu_src,
  output logic                  ex_sign_zero,
  output logic                  ex_branch,
  output logic                  ex_branch_ne,
  output logic [2:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_memto_reg,
  output logic                  illegal_op,
  output logic [5:0]            illegal_opcode
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] dest,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rt,
                                   input logic use_rs, input logic use_rt);
    src_hit = (dest != '0) && ((use_rs && dest == rs) || (use_rt && dest == rt));
  endfunction

  logic       d_reg_dst, d_reg_write, d_alu_src, d_mem_read, d_mem_write;
  logic       d_memto_reg, d_branch, d_branch_ne, d_sign_zero, d_jump, d_known;
  logic [2:0] d_alu_op;
  logic [REG_ADDR_W-1:0] d_dest;
  logic       use_rs, use_rt, load_use, stall, jump_take, idex_load;

  // ID/EX stage registers
  logic       alu_src_p1, sign_zero_p1, branch_p1, branch_ne_p1;
  logic       mem_read_p1, mem_write_p1, reg_write_p1, memto_reg_p1;
  logic [2:0] alu_op_p1;
  logic [REG_ADDR_W-1:0] dest_p1;

  // MEM stage registers, index 0 is the first MEM stage
  logic [MEM_LATENCY-1:0] mem_read_p2, mem_write_p2, reg_write_p2, memto_reg_p2;
  logic [REG_ADDR_W-1:0]  dest_p2 [MEM_LATENCY];

  // WB stage registers
  logic reg_write_p3, memto_reg_p3;
  logic [REG_ADDR_W-1:0] dest_p3;

  always_comb begin
    d_reg_dst = 1'b0; d_reg_write = 1'b0; d_alu_src = 1'b0; d_mem_read = 1'b0;
    d_mem_write = 1'b0; d_memto_reg = 1'b0; d_branch = 1'b0; d_branch_ne = 1'b0;
    d_sign_zero = 1'b0; d_jump = 1'b0; d_known = 1'b1; d_alu_op = 3'b000;
    case (id_opcode)
      OP_R:    begin d_reg_dst = 1'b1; d_reg_write = 1'b1; end
      OP_LW:   begin d_alu_src = 1'b1; d_mem_read = 1'b1; d_memto_reg = 1'b1;
                     d_reg_write = 1'b1; d_alu_op = 3'b001; end
      OP_SW:   begin d_alu_src = 1'b1; d_mem_write = 1'b1; d_alu_op = 3'b001; end
      OP_BEQ:  begin d_branch = 1'b1; d_alu_op = 3'b010; end
      OP_BNE:  begin d_branch = 1'b1; d_branch_ne = 1'b1; d_alu_op = 3'b010; end
      OP_J:    d_jump = 1'b1;
      OP_ADDI: begin d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = 3'b001; end
      OP_ANDI: begin d_alu_src = 1'b1; d_reg_write = 1'b1; d_sign_zero = 1'b1;
                     d_alu_op = 3'b011; end
      OP_ORI:  begin d_alu_src = 1'b1; d_reg_write = 1'b1; d_sign_zero = 1'b1;
                     d_alu_op = 3'b100; end
      OP_SLTI: begin d_alu_src = 1'b1; d_reg_write = 1'b1; d_alu_op = 3'b101; end
      default: d_known = 1'b0;
    endcase
    d_dest = d_reg_dst ? id_rd : id_rt;
    // Writes to $0 are architecturally discarded, so never carry them.
    if (d_dest == '0) d_reg_write = 1'b0;
  end

  always_comb begin
    use_rs = (id_opcode != OP_J);
    use_rt = (id_opcode == OP_R) || (id_opcode == OP_SW) ||
             (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);
    load_use = 1'b0;
    if (id_valid) begin
      if (mem_read_p1 && src_hit(dest_p1, id_rs, id_rt, use_rs, use_rt))
        load_use = 1'b1;
      // The last MEM stage forwards its data in time, so it is not a hazard.
      for (int i = 0; i < MEM_LATENCY - 1; i++)
        if (mem_read_p2[i] && src_hit(dest_p2[i], id_rs, id_rt, use_rs, use_rt))
          load_use = 1'b1;
    end
    // A flush discards the ID instruction, so its hazard no longer matters.
    stall     = load_use && !ex_flush;
    jump_take = id_valid && d_jump && !stall && !ex_flush;
    idex_load = id_valid && d_known && !d_jump && !stall && !ex_flush;
  end

  assign pc_write_en   = !stall;
  assign ifid_write_en = !stall;
  assign id_jump       = jump_take;
  assign ifid_flush    = ex_flush || jump_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_src_p1 <= 1'b0; sign_zero_p1 <= 1'b0; branch_p1 <= 1'b0;
      branch_ne_p1 <= 1'b0; mem_read_p1 <= 1'b0; mem_write_p1 <= 1'b0;
      reg_write_p1 <= 1'b0; memto_reg_p1 <= 1'b0; alu_op_p1 <= '0; dest_p1 <= '0;
      mem_read_p2 <= '0; mem_write_p2 <= '0; reg_write_p2 <= '0; memto_reg_p2 <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) dest_p2[i] <= '0;
      reg_write_p3 <= 1'b0; memto_reg_p3 <= 1'b0; dest_p3 <= '0;
    end else begin
      // ID -> EX: decoded word or bubble
      alu_src_p1   <= idex_load && d_alu_src;
      sign_zero_p1 <= idex_load && d_sign_zero;
      branch_p1    <= idex_load && d_branch;
      branch_ne_p1 <= idex_load && d_branch_ne;
      mem_read_p1  <= idex_load && d_mem_read;
      mem_write_p1 <= idex_load && d_mem_write;
      reg_write_p1 <= idex_load && d_reg_write;
      memto_reg_p1 <= idex_load && d_memto_reg;
      alu_op_p1    <= idex_load ? d_alu_op : 3'b000;
      dest_p1      <= idex_load ? d_dest : '0;
      // EX -> MEM shift chain
      mem_read_p2[0]  <= mem_read_p1;
      mem_write_p2[0] <= mem_write_p1;
      reg_write_p2[0] <= reg_write_p1;
      memto_reg_p2[0] <= memto_reg_p1;
      dest_p2[0]      <= dest_p1;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        mem_read_p2[i]  <= mem_read_p2[i-1];
        mem_write_p2[i] <= mem_write_p2[i-1];
        reg_write_p2[i] <= reg_write_p2[i-1];
        memto_reg_p2[i] <= memto_reg_p2[i-1];
        dest_p2[i]      <= dest_p2[i-1];
      end
      // MEM -> WB
      reg_write_p3 <= reg_write_p2[MEM_LATENCY-1];
      memto_reg_p3 <= memto_reg_p2[MEM_LATENCY-1];
      dest_p3      <= dest_p2[MEM_LATENCY-1];
    end
  end

  assign ex_alu_src   = alu_src_p1;
  assign ex_sign_zero = sign_zero_p1;
  assign ex_branch    = branch_p1;
  assign ex_branch_ne = branch_ne_p1;
  assign ex_alu_op    = alu_op_p1;
  assign ex_dest      = dest_p1;
  // Memory strobes stay high while the access occupies any MEM stage.
  assign mem_read     = |mem_read_p2;
  assign mem_write    = |mem_write_p2;
  assign mem_dest     = dest_p2[MEM_LATENCY-1];
  assign wb_reg_write = reg_write_p3;
  assign wb_memto_reg = memto_reg_p3;
  assign wb_dest      = dest_p3;

`ifdef ILLEGAL_OP_TRAP_EN
  logic       trap_p1;
  logic [5:0] trap_op_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_p1    <= 1'b0;
      trap_op_p1 <= '0;
    end else if (id_valid && !d_known && !stall && !ex_flush) begin
      trap_p1 <= 1'b1;
      if (!trap_p1) trap_op_p1 <= id_opcode;
    end
  end

  assign illegal_op     = trap_p1;
  assign illegal_opcode = trap_op_p1;
`else
  assign illegal_op     = 1'b0;
  assign illegal_opcode = 6'b000000;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_control_unit
//
// Directed bench for pipe_control_unit. Two instances share the ID inputs:
// u1 with MEM_LATENCY = 1 and u3 with MEM_LATENCY = 3 (only used for the
// multi-cycle load-use stall count).
// -----------------------------------------------------------------------------
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       reset, id_valid, ex_flush;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       pc_write_en, ifid_write_en, ifid_flush, id_jump;
  logic       ex_alu_src, ex_sign_zero, ex_branch, ex_branch_ne;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_dest, mem_dest, wb_dest;
  logic       mem_read, mem_write, wb_reg_write, wb_memto_reg, illegal_op;
  logic [5:0] illegal_opcode;

  logic       d3_pc_write_en, d3_ifid_write_en, d3_ifid_flush, d3_id_jump;
  logic       d3_ex_alu_src, d3_ex_sign_zero, d3_ex_branch, d3_ex_branch_ne;
  logic [2:0] d3_ex_alu_op;
  logic [4:0] d3_ex_dest, d3_mem_dest, d3_wb_dest;
  logic       d3_mem_read, d3_mem_write, d3_wb_reg_write, d3_wb_memto_reg, d3_illegal_op;
  logic [5:0] d3_illegal_opcode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.REG_ADDR_W(5), .MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .id_jump(id_jump), .ex_alu_src(ex_alu_src),
    .ex_sign_zero(ex_sign_zero), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
    .ex_alu_op(ex_alu_op), .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
    .wb_memto_reg(wb_memto_reg), .illegal_op(illegal_op), .illegal_opcode(illegal_opcode)
  );

  pipe_control_unit #(.REG_ADDR_W(5), .MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush),
    .pc_write_en(d3_pc_write_en), .ifid_write_en(d3_ifid_write_en),
    .ifid_flush(d3_ifid_flush), .id_jump(d3_id_jump), .ex_alu_src(d3_ex_alu_src),
    .ex_sign_zero(d3_ex_sign_zero), .ex_branch(d3_ex_branch), .ex_branch_ne(d3_ex_branch_ne),
    .ex_alu_op(d3_ex_alu_op), .ex_dest(d3_ex_dest), .mem_dest(d3_mem_dest),
    .wb_dest(d3_wb_dest), .mem_read(d3_mem_read), .mem_write(d3_mem_write),
    .wb_reg_write(d3_wb_reg_write), .wb_memto_reg(d3_wb_memto_reg),
    .illegal_op(d3_illegal_op), .illegal_opcode(d3_illegal_opcode)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ex_flush = 1'b0;
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_id(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);           // lw $4,0($1)
    tick();
    set_id(1'b1, 6'b000000, 5'd4, 5'd4, 5'd5);           // add $5,$4,$4
    checks++;
    if (pc_write_en !== 1'b0) begin failures++;
      $display("FAIL reset_prestall pc_write_en got=%0b exp=0", pc_write_en); end
    reset = 1'b1;
    tick();
    checks++;
    if (pc_write_en !== 1'b1) begin failures++;
      $display("FAIL reset_pc_write_en got=%0b exp=1", pc_write_en); end
    checks++;
    if (ifid_write_en !== 1'b1 || ifid_flush !== 1'b0 || id_jump !== 1'b0) begin failures++;
      $display("FAIL reset_ifid got=%0b%0b%0b exp=100", ifid_write_en, ifid_flush, id_jump); end
    checks++;
    if (ex_dest !== 5'd0 || ex_alu_src !== 1'b0 || ex_alu_op !== 3'd0) begin failures++;
      $display("FAIL reset_ex got dest=%0d src=%0b op=%0d exp=0/0/0", ex_dest, ex_alu_src, ex_alu_op); end
    checks++;
    if (mem_read !== 1'b0 || mem_dest !== 5'd0 || wb_reg_write !== 1'b0) begin failures++;
      $display("FAIL reset_mem_wb got rd=%0b md=%0d wr=%0b exp=0/0/0", mem_read, mem_dest, wb_reg_write); end
    checks++;
    if (illegal_op !== 1'b0 || illegal_opcode !== 6'd0) begin failures++;
      $display("FAIL reset_illegal got=%0b/%0d exp=0/0", illegal_op, illegal_opcode); end
    reset = 1'b0;
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_rtype();
    do_reset();
    set_id(1'b1, 6'b000000, 5'd1, 5'd2, 5'd3);           // add $3,$1,$2
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ex_alu_op !== 3'b000 || ex_dest !== 5'd3 || ex_alu_src !== 1'b0) begin failures++;
      $display("FAIL rtype_ex got op=%0d dest=%0d src=%0b exp=0/3/0", ex_alu_op, ex_dest, ex_alu_src); end
    tick();
    checks++;
    if (mem_dest !== 5'd3 || mem_read !== 1'b0) begin failures++;
      $display("FAIL rtype_mem got dest=%0d rd=%0b exp=3/0", mem_dest, mem_read); end
    tick();
    checks++;
    if (wb_reg_write !== 1'b1 || wb_dest !== 5'd3 || wb_memto_reg !== 1'b0) begin failures++;
      $display("FAIL rtype_wb got wr=%0b dest=%0d m2r=%0b exp=1/3/0", wb_reg_write, wb_dest, wb_memto_reg); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);           // lw $4,0($1)
    checks++;
    if (pc_write_en !== 1'b1) begin failures++;
      $display("FAIL lu_no_stall_yet got=%0b exp=1", pc_write_en); end
    tick();
    set_id(1'b1, 6'b000000, 5'd4, 5'd4, 5'd5);           // add $5,$4,$4
    checks++;
    if (pc_write_en !== 1'b0 || ifid_write_en !== 1'b0) begin failures++;
      $display("FAIL lu_stall got pc=%0b ifid=%0b exp=0/0", pc_write_en, ifid_write_en); end
    checks++;
    if (ex_alu_src !== 1'b1 || ex_dest !== 5'd4 || ex_alu_op !== 3'b001) begin failures++;
      $display("FAIL lu_lw_ex got src=%0b dest=%0d op=%0d exp=1/4/1", ex_alu_src, ex_dest, ex_alu_op); end
    tick();
    checks++;
    if (pc_write_en !== 1'b1 || ifid_write_en !== 1'b1) begin failures++;
      $display("FAIL lu_release got pc=%0b ifid=%0b exp=1/1", pc_write_en, ifid_write_en); end
    checks++;
    if (ex_dest !== 5'd0 || ex_alu_src !== 1'b0 || ex_alu_op !== 3'd0) begin failures++;
      $display("FAIL lu_bubble got dest=%0d src=%0b op=%0d exp=0/0/0", ex_dest, ex_alu_src, ex_alu_op); end
    checks++;
    if (mem_read !== 1'b1 || mem_dest !== 5'd4) begin failures++;
      $display("FAIL lu_mem got rd=%0b dest=%0d exp=1/4", mem_read, mem_dest); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ex_dest !== 5'd5 || wb_dest !== 5'd4 || wb_memto_reg !== 1'b1 || wb_reg_write !== 1'b1) begin
      failures++;
      $display("FAIL lu_after got exd=%0d wbd=%0d m2r=%0b wr=%0b exp=5/4/1/1",
               ex_dest, wb_dest, wb_memto_reg, wb_reg_write); end
  endtask

  task automatic test_load_use_lat3();
    int n;
    do_reset();
    set_id(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);           // lw $4,0($1)
    tick();
    set_id(1'b1, 6'b000000, 5'd4, 5'd4, 5'd5);           // add $5,$4,$4
    n = 0;
    while (d3_pc_write_en === 1'b0 && n < 10) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 3) begin failures++;
      $display("FAIL lat3_stall_cycles got=%0d exp=3", n); end
    checks++;
    if (d3_mem_read !== 1'b1 || d3_mem_dest !== 5'd4) begin failures++;
      $display("FAIL lat3_mem got rd=%0b dest=%0d exp=1/4", d3_mem_read, d3_mem_dest); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (d3_ex_dest !== 5'd5) begin failures++;
      $display("FAIL lat3_add_ex got=%0d exp=5", d3_ex_dest); end
  endtask

  task automatic test_no_stall();
    do_reset();
    set_id(1'b1, 6'b100011, 5'd1, 5'd0, 5'd0);           // lw $0,0($1)
    tick();
    set_id(1'b1, 6'b000000, 5'd0, 5'd0, 5'd5);           // add $5,$0,$0
    checks++;
    if (pc_write_en !== 1'b1) begin failures++;
      $display("FAIL nostall_zero got=%0b exp=1", pc_write_en); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++;
    if (wb_reg_write !== 1'b0 || wb_memto_reg !== 1'b1) begin failures++;
      $display("FAIL nostall_wb_zero got wr=%0b m2r=%0b exp=0/1", wb_reg_write, wb_memto_reg); end
    do_reset();
    set_id(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);           // lw $4,0($1)
    tick();
    set_id(1'b1, 6'b001000, 5'd7, 5'd4, 5'd0);           // addi $4,$7,1 (rt is dest)
    checks++;
    if (pc_write_en !== 1'b1 || ifid_write_en !== 1'b1) begin failures++;
      $display("FAIL nostall_addi_rt got pc=%0b ifid=%0b exp=1/1", pc_write_en, ifid_write_en); end
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_flush_over_stall();
    do_reset();
    set_id(1'b1, 6'b100011, 5'd1, 5'd4, 5'd0);           // lw $4
    tick();
    set_id(1'b1, 6'b000000, 5'd4, 5'd4, 5'd5);           // dependent add
    ex_flush = 1'b1;
    #1;
    checks++;
    if (pc_write_en !== 1'b1 || ifid_write_en !== 1'b1 || ifid_flush !== 1'b1) begin failures++;
      $display("FAIL flush_override got pc=%0b ifid=%0b fl=%0b exp=1/1/1",
               pc_write_en, ifid_write_en, ifid_flush); end
    tick();
    ex_flush = 1'b0;
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ex_dest !== 5'd0 || ex_alu_src !== 1'b0 || ex_alu_op !== 3'd0) begin failures++;
      $display("FAIL flush_bubble got dest=%0d src=%0b op=%0d exp=0/0/0", ex_dest, ex_alu_src, ex_alu_op); end
  endtask

  task automatic test_jump();
    do_reset();
    set_id(1'b1, 6'b001000, 5'd1, 5'd9, 5'd0);           // addi $9,$1,imm
    tick();
    set_id(1'b1, 6'b000010, 5'd3, 5'd3, 5'd3);           // j
    checks++;
    if (id_jump !== 1'b1 || ifid_flush !== 1'b1) begin failures++;
      $display("FAIL jump_id got jmp=%0b fl=%0b exp=1/1", id_jump, ifid_flush); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (id_jump !== 1'b0 || ifid_flush !== 1'b0) begin failures++;
      $display("FAIL jump_one_cycle got jmp=%0b fl=%0b exp=0/0", id_jump, ifid_flush); end
    checks++;
    if (ex_alu_src !== 1'b0 || ex_branch !== 1'b0 || ex_alu_op !== 3'd0 || ex_dest !== 5'd0) begin
      failures++;
      $display("FAIL jump_ex_bubble got src=%0b br=%0b op=%0d dest=%0d exp=0/0/0/0",
               ex_alu_src, ex_branch, ex_alu_op, ex_dest); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 6'b001100, 5'd1, 5'd8, 5'd0);           // andi
    tick();
    set_id(1'b1, 6'b001101, 5'd1, 5'd9, 5'd0);           // ori
    checks++;
    if (ex_sign_zero !== 1'b1 || ex_alu_op !== 3'b011 || ex_dest !== 5'd8) begin failures++;
      $display("FAIL b2b_andi got sz=%0b op=%0d dest=%0d exp=1/3/8", ex_sign_zero, ex_alu_op, ex_dest); end
    tick();
    set_id(1'b1, 6'b000101, 5'd2, 5'd3, 5'd0);           // bne
    checks++;
    if (ex_sign_zero !== 1'b1 || ex_alu_op !== 3'b100) begin failures++;
      $display("FAIL b2b_ori got sz=%0b op=%0d exp=1/4", ex_sign_zero, ex_alu_op); end
    tick();
    set_id(1'b1, 6'b001010, 5'd2, 5'd10, 5'd0);          // slti
    checks++;
    if (ex_branch !== 1'b1 || ex_branch_ne !== 1'b1 || ex_alu_op !== 3'b010 || ex_alu_src !== 1'b0) begin
      failures++;
      $display("FAIL b2b_bne got br=%0b ne=%0b op=%0d src=%0b exp=1/1/2/0",
               ex_branch, ex_branch_ne, ex_alu_op, ex_alu_src); end
    tick();
    set_id(1'b1, 6'b101011, 5'd2, 5'd3, 5'd0);           // sw
    checks++;
    if (ex_alu_op !== 3'b101 || ex_alu_src !== 1'b1 || ex_branch !== 1'b0 || ex_sign_zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_slti got op=%0d src=%0b br=%0b sz=%0b exp=5/1/0/0",
               ex_alu_op, ex_alu_src, ex_branch, ex_sign_zero); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++;
      $display("FAIL b2b_sw_mem got wr=%0b rd=%0b exp=1/0", mem_write, mem_read); end
    tick();
    checks++;
    if (wb_reg_write !== 1'b0) begin failures++;
      $display("FAIL b2b_sw_wb got=%0b exp=0", wb_reg_write); end
  endtask

  task automatic test_illegal();
    logic       exp_op;
    logic [5:0] exp_code;
`ifdef ILLEGAL_OP_TRAP_EN
    exp_op = 1'b1; exp_code = 6'b111111;
`else
    exp_op = 1'b0; exp_code = 6'b000000;
`endif
    do_reset();
    set_id(1'b1, 6'b111111, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(1'b1, 6'b110000, 5'd1, 5'd2, 5'd3);
    checks++;
    if (ex_alu_src !== 1'b0 || ex_dest !== 5'd0 || ex_alu_op !== 3'd0) begin failures++;
      $display("FAIL illegal_bubble got src=%0b dest=%0d op=%0d exp=0/0/0", ex_alu_src, ex_dest, ex_alu_op); end
    tick();
    set_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++;
    if (illegal_op !== exp_op || illegal_opcode !== exp_code) begin failures++;
      $display("FAIL illegal_trap got=%0b/%b exp=%0b/%b", illegal_op, illegal_opcode, exp_op, exp_code); end
  endtask

  initial begin
    reset = 1'b1; ex_flush = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    test_reset();
    test_rtype();
    test_load_use();
    test_load_use_lat3();
    test_no_stall();
    test_flush_over_stall();
    test_jump();
    test_back_to_back();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
